encoder_scan_ctrl: RTL and testbench
====================================

# encoder_scan_ctrl

Measurement scheduler that shares one edge-counting rpm datapath among up to N_CH motor-encoder inputs. Channels are serviced round-robin, skipping masked channels. For each channel it synchronizes the encoder line, waits a settle interval, and counts rising edges over a fixed gate window. It then scales the edge count to rpm and presents the result on a valid/ready output toward the speed register bank.

## Interface
- N_CH, 4: number of encoder inputs (2..16).
- CLK_PERIOD, 100: clock period in ns (10 MHz).
- PPR, 10: encoder pulses per revolution.
- GATE_MS, 100: gate window per channel in ms; GATE_CYCLES = GATE_MS*1_000_000/CLK_PERIOD.
- SETTLE_CYCLES, 4: settle cycles after a channel switch (>=1).
- K (localparam) = 60_000/(PPR*GATE_MS); elaboration must fail unless it divides exactly (defaults: K=60).

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- enc  in  N_CH  raw encoder lines, asynchronous to clk.
- enable  in  1  run scan when high.
- ch_mask  in  N_CH  1 = channel participates; sampled when the next channel is chosen.
- rpm_out  out  32  scaled rpm of last completed channel.
- rpm_ch  out  clog2(N_CH)  channel index of rpm_out.
- rpm_valid  out  1  result available; held until accepted.
- rpm_ready  in  1  consumer accepts when rpm_valid && rpm_ready.
- busy  out  1  high in any state except IDLE.

## Operation
- Every enc bit passes through a 2-flop synchronizer that runs continuously, independent of state.
- The selected channel's synchronized bit feeds a single edge detector built from a prev register.
- The edge counter is 24 bits and saturates at 2^24-1.
- FSM states: IDLE, SETTLE, GATE, CALC, OUTPUT.
- IDLE: if enable && |ch_mask, select the lowest set mask bit, clear the counter, and go to SETTLE. Otherwise stay in IDLE.
- SETTLE: lasts SETTLE_CYCLES cycles. prev is loaded with the selected bit every cycle, so a line that is already high does not count as an edge. Then go to GATE.
- GATE: lasts exactly GATE_CYCLES cycles. Each cycle with sync=1 && prev=0 increments the counter. Then go to CALC.
- CALC: one cycle. Computes rpm_out = min(count*K, 2^32-1) and rpm_ch = current channel. Then go to OUTPUT.
- OUTPUT: rpm_valid=1, with rpm_out and rpm_ch held stable.
- Handshake completion in OUTPUT:
  - If enable=0 or ch_mask=0: go to IDLE.
  - Otherwise: select the next set mask bit above the current channel, wrapping to the lowest. A single set bit reselects the same channel. Go to SETTLE.
- Deasserting enable during SETTLE or GATE does not abort. The in-flight measurement completes and is delivered, then the FSM goes to IDLE.
- A ch_mask change mid-measurement does not affect the current channel.
- Reset (rst=0, any time):
  - All registers clear immediately.
  - Outputs: rpm_out=0, rpm_ch=0, rpm_valid=0, busy=0.
  - State goes to IDLE and the synchronizers clear.

## Timing
- enc to edge detection: 2 cycles synchronizer latency.
- IDLE to first rpm_valid: 1 + SETTLE_CYCLES + GATE_CYCLES + 1 cycles after the cycle that samples enable=1.
- rpm_valid rises on the clock edge leaving CALC.
- rpm_valid falls on the clock edge where the handshake completes. SETTLE for the next channel begins that same edge.
- No bubble cycle is inserted between handshake and SETTLE.
- Back-to-back period per channel with rpm_ready=1: SETTLE_CYCLES + GATE_CYCLES + 2 cycles.
- Backpressure: while rpm_ready=0, the FSM stays in OUTPUT. No counting occurs and edges are ignored.
- busy rises the cycle after IDLE accepts enable. It falls on the edge entering IDLE.

## Test plan
- Reset: hold rst=0 for 5 cycles with enc toggling → rpm_out=0, rpm_valid=0, busy=0. After releasing rst with enable=0, busy stays 0.
- Single channel: ch_mask=0001, enable=1, enc[0] square wave with 6 ms period (3 ms high/3 ms low) → rpm_valid with rpm_ch=0 and rpm_out in {960, 1020}. This repeats every 1_000_006 cycles with rpm_ready=1.
- Round robin: ch_mask=1011, enc[0] at 6 ms period, enc[1] held high, enc[3] at 1 ms period → results in channel order 0, 1, 3, 0. Values: rpm_out 960/1020, 0, 6000.
- Backpressure: rpm_ready=0 for 50 cycles during OUTPUT → rpm_valid, rpm_out and rpm_ch stable. After rpm_ready=1, SETTLE of the next channel starts on the acceptance edge.
- Enable drop: deassert enable halfway through GATE → that channel's result is still delivered, then busy=0. With enable=1 and ch_mask=0, FSM stays in IDLE.
- Reset mid-GATE: pulse rst low during GATE → outputs clear in the same cycle, with no clock required. After release, scanning restarts at the lowest set mask channel.

Source files
------------

// File: rtl/encoder_scan_ctrl_if.sv
// Encoder scan bus: raw encoder lines and scan control in, rpm result out.
// Pure wiring, no latency.
// Result side is valid/ready; rpm_valid holds until rpm_ready accepts it.
interface encoder_scan_ctrl_if #(
  parameter int N_CH = 4
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0] enc;
  logic            enable;
  logic [N_CH-1:0] ch_mask;
  logic [31:0]     rpm_out;
  logic [CH_W-1:0] rpm_ch;
  logic            rpm_valid;
  logic            rpm_ready;
  logic            busy;

  // Host side: drives encoder lines, scan control and result acceptance.
  modport master (
    output enc, enable, ch_mask, rpm_ready,
    input  rpm_out, rpm_ch, rpm_valid, busy
  );

  // Scheduler side.
  modport slave (
    input  enc, enable, ch_mask, rpm_ready,
    output rpm_out, rpm_ch, rpm_valid, busy
  );
endinterface

// File: rtl/encoder_scan_ctrl.sv
// Round-robin rpm scheduler sharing one edge counter across N_CH encoder lines.
// Latency: 1 + SETTLE_CYCLES + GATE_CYCLES + 1 cycles from enable to first result.
// Backpressure: result held in OUTPUT while rpm_ready is low; no counting meanwhile.
module encoder_scan_ctrl #(
  parameter int N_CH          = 4,
  parameter int CLK_PERIOD    = 100,
  parameter int PPR           = 10,
  parameter int GATE_MS       = 100,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  encoder_scan_ctrl_if.slave   bus
);

  localparam int          CH_W          = $clog2(N_CH);
  localparam longint      GATE_CYCLES_L = (longint'(GATE_MS) * longint'(1_000_000)) / longint'(CLK_PERIOD);
  localparam logic [31:0] GATE_CYCLES   = 32'(GATE_CYCLES_L);
  localparam logic [31:0] SETTLE_LEN    = 32'(SETTLE_CYCLES);
  localparam int          K             = 60_000 / (PPR * GATE_MS);
  localparam logic [31:0] K_W           = 32'(K);

  // Refuse to build with a non-integer rpm scale or degenerate timing.
  if ((60_000 % (PPR * GATE_MS)) != 0 || K == 0) begin : g_k_check
    $error("encoder_scan_ctrl: 60000/(PPR*GATE_MS) must be an exact non-zero integer");
  end
  if (SETTLE_CYCLES < 1 || GATE_CYCLES_L < 1 || N_CH < 2 || N_CH > 16) begin : g_param_check
    $error("encoder_scan_ctrl: SETTLE_CYCLES, GATE_CYCLES must be >= 1 and N_CH in 2..16");
  end

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, CALC, OUTPUT} state_t;

  state_t          state, state_nxt;
  logic [N_CH-1:0] sync1, sync2;
  logic [CH_W-1:0] cur_ch, first_ch, next_ch, idx_w;
  logic [31:0]     timer;
  logic [23:0]     count;
  logic            prev;
  logic            sel_bit;
  logic            found;
  logic            go_on;
  logic [55:0]     prod;
  logic [31:0]     rpm_q;
  logic [CH_W-1:0] rpm_ch_q;

  assign sel_bit = sync2[cur_ch];
  assign go_on   = bus.enable && (|bus.ch_mask);

  // Two-flop synchronizer on every encoder line, always running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.enc;
      sync2 <= sync1;
    end
  end

  // Lowest set mask bit, used when starting a scan from IDLE.
  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_ch = CH_W'(i);
    end
  end

  // Next set mask bit above the current channel, wrapping; a lone bit reselects itself.
  always_comb begin
    next_ch = cur_ch;
    found   = 1'b0;
    idx_w   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx_w = CH_W'((int'(cur_ch) + i) % N_CH);
      if (!found && bus.ch_mask[idx_w]) begin
        next_ch = idx_w;
        found   = 1'b1;
      end
    end
  end

  // count*K, saturated to 32 bits.
  always_comb begin
    prod = 56'(count) * 56'(K_W);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; enable and mask are only consulted in IDLE and at handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_on) state_nxt = SETTLE;
      SETTLE:  if (timer == '0) state_nxt = GATE;
      GATE:    if (timer == '0) state_nxt = CALC;
      CALC:    state_nxt = OUTPUT;
      OUTPUT:  if (bus.rpm_ready) state_nxt = go_on ? SETTLE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state plus the held result registers.
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.rpm_valid = (state == OUTPUT);
    bus.rpm_out   = rpm_q;
    bus.rpm_ch    = rpm_ch_q;
  end

  // Measurement datapath: channel select, phase timer, edge counter, result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_ch   <= '0;
      timer    <= '0;
      count    <= '0;
      prev     <= 1'b0;
      rpm_q    <= '0;
      rpm_ch_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_on) begin
            cur_ch <= first_ch;
            count  <= '0;
            timer  <= SETTLE_LEN - 32'd1;
          end
        end
        SETTLE: begin
          // Track the line so a level already high is not taken as an edge.
          prev <= sel_bit;
          if (timer == '0) timer <= GATE_CYCLES - 32'd1;
          else             timer <= timer - 32'd1;
        end
        GATE: begin
          prev <= sel_bit;
          if (sel_bit && !prev && (count != '1)) count <= count + 24'd1;
          if (timer != '0) timer <= timer - 32'd1;
        end
        CALC: begin
          rpm_q    <= (|prod[55:32]) ? 32'hFFFF_FFFF : prod[31:0];
          rpm_ch_q <= cur_ch;
        end
        OUTPUT: begin
          if (bus.rpm_ready && go_on) begin
            cur_ch <= next_ch;
            count  <= '0;
            timer  <= SETTLE_LEN - 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_scan_ctrl.sv
// Scoreboard bench for encoder_scan_ctrl with a short gate window (50 cycles, K=6000).
// Encoder generators run free; square-wave periods dividing 50 give exact edge counts.
// Stimulus pushes expected results; a monitor pops them on each accepted handshake.
module tb_encoder_scan_ctrl;

  localparam int N_CH          = 4;
  localparam int CLK_PERIOD    = 20_000;  // 20 us per cycle -> 1 ms gate = 50 cycles
  localparam int PPR           = 10;
  localparam int GATE_MS       = 1;
  localparam int SETTLE_CYCLES = 4;
  localparam int FIRST_LAT     = 56;      // 1 + 4 + 50 + 1
  localparam int LIMIT         = 2000;

  typedef struct {
    int     ch;
    longint rpm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t got;
  int   per [N_CH] = '{0, 0, 0, 0};
  int   ph  [N_CH] = '{0, 0, 0, 0};
  logic [N_CH-1:0] lvl = '0;
  logic [N_CH-1:0] enc_nxt;
  int   lat;

  encoder_scan_ctrl_if #(.N_CH(N_CH)) bus ();

  encoder_scan_ctrl #(
    .N_CH(N_CH), .CLK_PERIOD(CLK_PERIOD), .PPR(PPR),
    .GATE_MS(GATE_MS), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int ch, input longint rpm);
    exp_t e;
    e.ch  = ch;
    e.rpm = rpm;
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.rpm_valid && n < LIMIT) begin
      step();
      n++;
    end
    if (!bus.rpm_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: timeout after %0d cycles, expected rpm_valid=1", n);
    end
  endtask

  // Free-running encoder generators: per=0 means constant level from lvl.
  initial begin
    bus.enc = '0;
    forever begin
      @(negedge clk);
      enc_nxt = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (per[i] == 0) enc_nxt[i] = lvl[i];
        else begin
          ph[i]      = (ph[i] + 1) % per[i];
          enc_nxt[i] = (ph[i] < per[i] / 2);
        end
      end
      bus.enc = enc_nxt;
    end
  end

  // Monitor: every accepted result must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.rpm_valid && bus.rpm_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got ch=%0d rpm=%0d, expected none", bus.rpm_ch, bus.rpm_out);
        end else begin
          got = exp_q.pop_front();
          chk("result_ch", longint'(bus.rpm_ch), longint'(got.ch));
          chk("result_rpm", longint'(bus.rpm_out), got.rpm);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable    = 1'b0;
    bus.ch_mask   = '0;
    bus.rpm_ready = 1'b1;
    per[0] = 3; per[1] = 4; per[2] = 5; per[3] = 6;

    // Reset held with encoders toggling.
    repeat (5) step();
    chk("rst_rpm_out", longint'(bus.rpm_out), 0);
    chk("rst_rpm_ch", longint'(bus.rpm_ch), 0);
    chk("rst_valid", longint'(bus.rpm_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    rst = 1'b1;
    repeat (5) step();
    chk("idle_busy_enable0", longint'(bus.busy), 0);
    chk("idle_valid_enable0", longint'(bus.rpm_valid), 0);

    // Single channel, period 10 -> 5 edges -> 30000 rpm, twice back to back.
    per[0] = 10;
    bus.ch_mask = 4'b0001;
    push_exp(0, 30000);
    push_exp(0, 30000);
    bus.enable = 1'b1;
    wait_valid(lat);
    chk("first_latency", longint'(lat), FIRST_LAT);
    step();
    chk("b2b_valid_low", longint'(bus.rpm_valid), 0);
    wait_valid(lat);
    chk("b2b_period", longint'(1 + lat), FIRST_LAT);
    bus.enable = 1'b0;
    step();
    chk("single_busy_idle", longint'(bus.busy), 0);

    // Round robin over mask 1011: ch0 period 10, ch1 held high, ch3 period 5.
    per[1] = 0; lvl[1] = 1'b1; per[2] = 3; per[3] = 5;
    bus.ch_mask = 4'b1011;
    push_exp(0, 30000);
    push_exp(1, 0);
    push_exp(3, 60000);
    push_exp(0, 30000);
    bus.enable = 1'b1;
    repeat (3) begin
      wait_valid(lat);
      step();
    end
    wait_valid(lat);
    bus.enable = 1'b0;
    step();
    chk("rr_busy_idle", longint'(bus.busy), 0);

    // Backpressure on channel 2 (period 25 -> 2 edges -> 12000 rpm).
    per[2] = 25;
    bus.ch_mask   = 4'b0100;
    bus.rpm_ready = 1'b0;
    push_exp(2, 12000);
    push_exp(2, 12000);
    bus.enable = 1'b1;
    wait_valid(lat);
    repeat (50) begin
      step();
      chk("bp_valid", longint'(bus.rpm_valid), 1);
      chk("bp_rpm_out", longint'(bus.rpm_out), 12000);
      chk("bp_rpm_ch", longint'(bus.rpm_ch), 2);
    end
    bus.rpm_ready = 1'b1;
    step();
    chk("bp_accept_valid_low", longint'(bus.rpm_valid), 0);
    chk("bp_accept_busy", longint'(bus.busy), 1);
    wait_valid(lat);
    chk("bp_settle_from_accept", longint'(lat), FIRST_LAT - 1);
    bus.enable = 1'b0;
    step();
    chk("bp_busy_idle", longint'(bus.busy), 0);

    // Enable dropped halfway through GATE on channel 3; result still delivered.
    bus.ch_mask = 4'b1000;
    push_exp(3, 60000);
    bus.enable = 1'b1;
    repeat (30) step();
    chk("drop_busy_mid_gate", longint'(bus.busy), 1);
    bus.enable = 1'b0;
    wait_valid(lat);
    step();
    chk("drop_busy_after", longint'(bus.busy), 0);
    bus.enable  = 1'b1;
    bus.ch_mask = 4'b0000;
    repeat (10) step();
    chk("mask0_busy", longint'(bus.busy), 0);
    chk("mask0_valid", longint'(bus.rpm_valid), 0);
    chk("held_rpm_ch", longint'(bus.rpm_ch), 3);

    // Reset mid-GATE clears outputs without a clock; rescan starts at ch1.
    per[1] = 25;
    bus.ch_mask = 4'b0110;
    repeat (30) step();
    rst = 1'b0;
    #1;
    chk("arst_rpm_out", longint'(bus.rpm_out), 0);
    chk("arst_rpm_ch", longint'(bus.rpm_ch), 0);
    chk("arst_valid", longint'(bus.rpm_valid), 0);
    chk("arst_busy", longint'(bus.busy), 0);
    repeat (2) step();
    rst = 1'b1;
    push_exp(1, 12000);
    wait_valid(lat);
    chk("rescan_latency", longint'(lat), FIRST_LAT);
    bus.enable = 1'b0;
    step();
    chk("rescan_busy_idle", longint'(bus.busy), 0);

    repeat (3) step();
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
